// File: rtl/mio_uart_pkg.sv
// Shared types and constants for the MIO UART transmitter peripheral.
package mio_uart_pkg;

    // Serialiser states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Status word bit positions.
    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_BUSY    = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 4;
    localparam int unsigned ST_CNT_MSB = 8;
    localparam int unsigned ST_IE      = 9;

    // Control register bit positions.
    localparam int unsigned CTL_IE     = 0;
    localparam int unsigned CTL_FLUSH  = 1;
    localparam int unsigned CTL_OVFCLR = 2;

    // Assemble the CPU-visible status word; unused bits read as zero.
    function automatic logic [31:0] pack_status(
        input logic       empty,
        input logic       full,
        input logic       busy,
        input logic       ovf,
        input logic [4:0] count,
        input logic       ie
    );
        logic [31:0] s;
        s                        = 32'h0000_0000;
        s[ST_EMPTY]              = empty;
        s[ST_FULL]               = full;
        s[ST_BUSY]               = busy;
        s[ST_OVF]                = ovf;
        s[ST_CNT_MSB:ST_CNT_LSB] = count;
        s[ST_IE]                 = ie;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop/flush; read data is the head entry, valid while not empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == {(PW+1){1'b0}});
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_q];
    // Fullness uses the pre-edge count, so a push into a full FIFO is dropped even if a pop happens.
    assign do_push_s = push_i & ~full_o & ~flush_i;
    assign do_pop_s  = pop_i & ~empty_o;

    // Pointer and occupancy next-state; a flush discards everything not popped this cycle.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = wr_q;
            count_d = {(PW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_d = wr_q + PW'(1);
            end else begin
                wr_d = wr_q;
            end
            if (do_pop_s) begin
                rd_d = rd_q + PW'(1);
            end else begin
                rd_d = rd_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q    <= {PW{1'b0}};
            rd_q    <= {PW{1'b0}};
            count_q <= {(PW+1){1'b0}};
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage array; no reset needed since entries are only read when counted valid.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mio_uart_tx.sv
// MIO UART transmitter: byte FIFO feeding an 8N1 serialiser, with status word and empty interrupt.
module mio_uart_tx
    import mio_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        irq
);
    localparam int unsigned BW = $clog2(BAUD_DIV);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_TC = BW'(BAUD_DIV - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          ovf_q, ovf_d;
    logic          ie_q, ie_d;
    logic          irq_q, irq_d;

    logic          data_wr_s;
    logic          ctl_wr_s;
    logic          flush_s;
    logic          pop_s;
    logic          baud_tc_s;
    logic [7:0]    fifo_head_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          unused_wdata_s;

    assign data_wr_s      = we & ~reg_sel;
    assign ctl_wr_s       = we & reg_sel;
    assign flush_s        = ctl_wr_s & wdata[CTL_FLUSH];
    assign baud_tc_s      = (baud_q == BAUD_TC);
    assign unused_wdata_s = ^wdata[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (data_wr_s),
        .push_data_i (wdata[7:0]),
        .pop_i       (pop_s),
        .flush_i     (flush_s),
        .head_o      (fifo_head_s),
        .count_o     (fifo_count_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // Serialiser next-state: txd_d is the line level for the cycle after the edge.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop_s     = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_head_s;
                    baud_d  = {BW{1'b0}};
                    state_d = START;
                    txd_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_tc_s) begin
                    baud_d    = {BW{1'b0}};
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                    txd_d     = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_tc_s) begin
                    baud_d = {BW{1'b0}};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_tc_s) begin
                    baud_d = {BW{1'b0}};
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_head_s;
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Control/status next-state: overflow flag, interrupt enable and interrupt level.
    always_comb begin
        ovf_d = ovf_q;
        ie_d  = ie_q;
        if (data_wr_s && fifo_full_s) begin
            ovf_d = 1'b1;
        end else if (ctl_wr_s && wdata[CTL_OVFCLR]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (ctl_wr_s) begin
            ie_d = wdata[CTL_IE];
        end else begin
            ie_d = ie_q;
        end
        irq_d = ie_q & fifo_empty_s & (state_q == IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= {BW{1'b0}};
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            txd_q     <= 1'b1;
            ovf_q     <= 1'b0;
            ie_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            ovf_q     <= ovf_d;
            ie_q      <= ie_d;
            irq_q     <= irq_d;
        end
    end

    assign txd   = txd_q;
    assign irq   = irq_q;
    assign rdata = pack_status(fifo_empty_s, fifo_full_s, (state_q != IDLE), ovf_q,
                               5'(fifo_count_s), ie_q);

endmodule

// File: tb/tb_mio_uart_tx.sv
// Bench for mio_uart_tx: waveform-level reference model checked every cycle, plus directed literals.
module tb_mio_uart_tx;
    localparam int BD    = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic        reg_sel = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        txd;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    mio_uart_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .reg_sel (reg_sel),
        .wdata   (wdata),
        .rdata   (rdata),
        .txd     (txd),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Reference model: pending bytes, and the remaining line levels of the frame on the wire.
    logic [7:0] m_q[$];
    bit         m_wave[$];
    logic       m_ovf = 1'b0;
    logic       m_ie = 1'b0;
    logic       m_irq = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_txd = 1'b1;
    int         m_cnt;
    logic [7:0] m_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, wanted %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete(); m_wave.delete();
            m_ovf = 1'b0; m_ie = 1'b0; m_irq = 1'b0; m_busy = 1'b0; m_txd = 1'b1;
        end else begin
            m_cnt = m_q.size();
            m_irq = m_ie && (m_cnt == 0) && !m_busy;
            if (m_wave.size() > 1) begin
                void'(m_wave.pop_front());
            end else begin
                m_wave.delete();
                if (m_cnt > 0) begin
                    m_byte = m_q.pop_front();
                    for (int c = 0; c < BD; c++) m_wave.push_back(1'b0);
                    for (int b = 0; b < 8; b++)
                        for (int c = 0; c < BD; c++) m_wave.push_back(m_byte[b]);
                    for (int c = 0; c < BD; c++) m_wave.push_back(1'b1);
                end
            end
            m_busy = (m_wave.size() > 0);
            m_txd  = m_busy ? m_wave[0] : 1'b1;
            if (we && !reg_sel) begin
                if (m_cnt < DEPTH) m_q.push_back(wdata[7:0]);
                else m_ovf = 1'b1;
            end
            if (we && reg_sel) begin
                m_ie = wdata[0];
                if (wdata[1]) m_q.delete();
                if (wdata[2]) m_ovf = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("cyc_txd", {31'd0, txd}, {31'd0, m_txd});
            check("cyc_irq", {31'd0, irq}, {31'd0, m_irq});
            check("cyc_rdata", rdata, {22'd0, m_ie, 5'(m_q.size()), m_ovf, m_busy,
                                       (m_q.size() == DEPTH), (m_q.size() == 0)});
        end
    end

    task automatic write(input logic sel, input logic [31:0] d);
        @(negedge clk); we = 1'b1; reg_sel = sel; wdata = d;
        @(negedge clk); we = 1'b0; reg_sel = 1'b0; wdata = 32'h0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((rdata[2] || !rdata[0]) && n <= 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, (n > 2000)}, 32'd0);
    endtask

    logic [9:0]  seq10;
    logic [29:0] seq30;
    int          busy_n;
    int          bad_n;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rdata", rdata, 32'h0000_0001);
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;

        // Single byte 0xA5.
        write(1'b0, 32'hA5);
        check("a5_pre_txd", {31'd0, txd}, 32'd1);
        check("a5_pre_rdata", rdata, 32'h0000_0010);
        seq10 = 10'b0101001011;
        busy_n = 0;
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            if (k < 40) check("a5_bit", {31'd0, txd}, {31'd0, seq10[9 - k / 4]});
            if (rdata[2]) busy_n++;
        end
        check("a5_busy_cycles", busy_n, 32'd40);

        // Back-to-back 0x01, 0x02, 0x03.
        @(negedge clk); we = 1'b1; reg_sel = 1'b0; wdata = 32'h01;
        @(negedge clk); wdata = 32'h02;
        @(negedge clk); wdata = 32'h03;
        @(negedge clk); we = 1'b0; wdata = 32'h0;
        check("b2b_count_start", {27'd0, rdata[8:4]}, 32'd2);
        seq30 = 30'b0100000001_0010000001_0110000001;
        busy_n = 0;
        for (int k = 1; k < 125; k++) begin
            if (k < 120) check("b2b_bit", {31'd0, txd}, {31'd0, seq30[29 - k / 4]});
            if (k == 40) check("b2b_count_pop2", {27'd0, rdata[8:4]}, 32'd1);
            if (k == 80) check("b2b_count_pop3", {27'd0, rdata[8:4]}, 32'd0);
            if (rdata[2]) busy_n++;
            @(negedge clk);
        end
        check("b2b_busy_cycles", busy_n, 32'd119);

        // Fill while a frame is in flight, overflow, clear, flush.
        write(1'b0, 32'h55);
        for (int i = 0; i < 8; i++) write(1'b0, 32'h60 + i);
        check("ovf_full", rdata, 32'h0000_0086);
        write(1'b0, 32'h77);
        check("ovf_set", rdata, 32'h0000_008E);
        write(1'b1, 32'h4);
        check("ovf_clear", rdata, 32'h0000_0086);
        write(1'b1, 32'h2);
        check("ovf_flush", rdata, 32'h0000_0005);
        wait_idle("ovf_idle_timeout");

        // Flush mid-frame with three bytes queued.
        write(1'b0, 32'h11);
        write(1'b0, 32'h22);
        write(1'b0, 32'h33);
        write(1'b0, 32'h44);
        check("flush_queued", rdata, 32'h0000_0034);
        repeat (4) @(negedge clk);
        write(1'b1, 32'h2);
        check("flush_after", rdata, 32'h0000_0005);
        wait_idle("flush_idle_timeout");
        bad_n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rdata[2] || !txd) bad_n++;
        end
        check("flush_no_more_frames", bad_n, 32'd0);

        // Interrupt enable and empty interrupt.
        write(1'b1, 32'h1);
        check("irq_ie_rdata", rdata, 32'h0000_0201);
        check("irq_pre", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_idle_high", {31'd0, irq}, 32'd1);
        write(1'b0, 32'h81);
        check("irq_push_still_high", {31'd0, irq}, 32'd1);
        bad_n = 0;
        for (int k = 0; k < 42; k++) begin
            @(negedge clk);
            if (k < 40 && (irq || !rdata[2])) bad_n++;
            if (k == 40) check("irq_stop_end", {30'd0, irq, rdata[2]}, 32'd0);
            if (k == 41) check("irq_rise", {31'd0, irq}, 32'd1);
        end
        check("irq_low_in_frame", bad_n, 32'd0);

        // Reset in the middle of the data bits.
        write(1'b0, 32'hF0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_txd", {31'd0, txd}, 32'd1);
        check("rst_async_rdata", rdata, 32'h0000_0001);
        check("rst_async_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        write(1'b0, 32'h3C);
        seq10 = 10'b0001111001;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("rst_new_bit", {31'd0, txd}, {31'd0, seq10[9 - k / 4]});
        end
        wait_idle("rst_idle_timeout");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, wanted finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mio_uart_tx.md
# mio_uart_tx

Memory-mapped UART transmitter peripheral hanging directly downstream of the MIO bus decoder, alongside the LED/GPIO and counter peripherals. The CPU writes bytes through the bus write strobe and data word. The block buffers them in a small FIFO and serialises them as 8N1 frames on `txd`. It returns a status word for CPU reads and raises an optional FIFO-empty interrupt.

## Interface
Parameters:
- `BAUD_DIV`, default 868: clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, default 8: FIFO entries; must be a power of two, 2..16.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `we`  in  1  single-cycle write strobe from the bus address decode.
- `reg_sel`  in  1  0 = TX data register, 1 = control register.
- `wdata`  in  32  bus write data (Peripheral_in).
- `rdata`  out  32  status word; combinational from registered state.
- `txd`  out  1  serial output; idles high.
- `irq`  out  1  interrupt request; level, registered.

## Operation
- Data write (`we`=1, `reg_sel`=0): pushes `wdata[7:0]` if not full. If full, the byte is dropped and sticky `ovf` is set. Fullness is judged on the pre-edge count, even if a pop occurs the same cycle.
- Control write (`we`=1, `reg_sel`=1):
  - bit0 → `ie`.
  - bit1 = 1 flushes the FIFO (count←0); the frame in progress is not aborted.
  - bit2 = 1 clears `ovf`.
- Simultaneous push and pop with count < FIFO_DEPTH: both take effect; count unchanged.
- `rdata` fields:
  - [0] empty
  - [1] full
  - [2] busy (FSM ≠ IDLE)
  - [3] ovf
  - [8:4] count (0..FIFO_DEPTH)
  - [9] ie
  - [31:10] = 0
- `irq` = `ie` & empty & ~busy, registered. It asserts one cycle after the last stop bit completes.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If FIFO non-empty: pop into shift register, baud_cnt←0, go to START.
  - START: `txd`=0 for BAUD_DIV cycles, then DATA with bit_idx←0.
  - DATA: `txd`=shift[0]; each BAUD_DIV cycles shift right and bit_idx++; after bit 7, go to STOP. Bits are sent LSB first.
  - STOP: `txd`=1 for BAUD_DIV cycles. Then, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Width rules:
  - baud_cnt is $clog2(BAUD_DIV) bits and counts 0..BAUD_DIV-1, wrapping to 0 at terminal count.
  - bit_idx is 3 bits.
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; count is one bit wider.
- Reset, including mid-frame:
  - `txd`=1, `irq`=0, state IDLE, FIFO empty, `ovf`=0, `ie`=0.
  - `rdata` = 32'h0000_0001.

## Timing
- Push at edge N: status reflects the new count after N.
- From IDLE, pop happens at edge N+1, and `txd` falls after N+1.
- Frame length is exactly 10·BAUD_DIV cycles. Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- `txd` is driven from a flop; no combinational path from bus inputs to `txd`.
- Flush in the same cycle as an IDLE pop: the pop wins for that entry; remaining entries are flushed.

## Structure
- Shared package `mio_uart_pkg`:
  - state enum (IDLE/START/DATA/STOP)
  - status bit-position constants (ST_EMPTY=0 … ST_IE=9)
  - control bit constants (CTL_IE=0, CTL_FLUSH=1, CTL_OVFCLR=2)
- Sub-module `sync_fifo` (parameterised width/depth, push/pop/flush, count/full/empty).
- The FSM, baud counter and shift register stay in the top of this block.

## Test plan
Benches use BAUD_DIV=4 and FIFO_DEPTH=8.
- Reset, then single data write of 0xA5:
  - `txd` falls one cycle after the push-visible edge.
  - `txd` sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - busy is 1 for exactly 40 cycles.
- Three consecutive writes 0x01, 0x02, 0x03:
  - 120 contiguous frame cycles with no high gap between the stop bit and the next start bit.
  - count decrements at each pop.
- Nine writes while the first frame is in flight:
  - full=1, then the 10th write sets ovf=1 and is dropped.
  - Control write of 0x4 clears ovf.
- Control write of 0x1, then one byte:
  - `irq` is 0 during the frame and rises one cycle after the stop bit ends.
  - A subsequent data write drops `irq` once the frame starts.
- Flush (0x2) mid-frame with 3 bytes queued:
  - The current frame completes intact.
  - No further frames are sent; rdata[8:4]=0.
- Assert `rst` during the DATA state:
  - `txd`=1 and `rdata`=0x00000001 asynchronously.
  - After release, a new write transmits cleanly.
